perf_monitor: RTL
=================

# perf_monitor

Synthesizable performance monitor for the pipelined ARM core. It watches the hazard unit's stall and forward signals, the execute-stage instruction and branch flag, and the fetch PC. Over one measurement window it accumulates cycles, stall cycles, stall events, approximate instructions and branches, and exposes them through a registered readout port. It sits beside the pipeline and feeds the simulation profiler and any on-chip debug reader, replacing per-cycle bench arithmetic with hardware counts.

## Interface
- WIDTH, 32: width of every counter and of RdData.
- HALT_PC, 32'hb6eac824: PCF value that ends the measurement window.
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high.
- StallF, StallD, StallE, StallM, StallW  in  1 each  hazard-unit stall outputs.
- ForwardAE, ForwardBE  in  2 each  hazard-unit forward selects; nonzero means forwarding.
- InstrE  in  32  execute-stage instruction.
- BranchE  in  1  execute-stage branch flag.
- PCF  in  32  fetch-stage PC.
- Start  in  1  single-cycle pulse: clear counters and open a window.
- RdSel  in  3  counter select for readout.
- RdData  out  WIDTH  registered readout.
- Running  out  1  high in RUN.
- Done  out  1  high in DONE.

## Operation
- FSM states are IDLE, RUN and DONE. Reset forces IDLE, clears all five counters, wasStalled and OldInstrE to 0, and drives RdData=0, Running=0, Done=0.
- IDLE: counters hold. Start=1 clears the counters, loads OldInstrE with InstrE, clears wasStalled, and moves to RUN.
- RUN: evaluated every cycle.
  - stall = OR of the five Stall inputs.
  - Cycles increments by 1.
  - StallCycles increments when stall=1.
  - StallEvents increments when stall=1 and wasStalled=0. wasStalled takes the value of stall.
  - chg = (InstrE != OldInstrE). Instrs increments when chg=1, or when chg=0 and (ForwardAE!=0 or ForwardBE!=0).
  - Branches increments when chg=1 and BranchE=1.
  - OldInstrE takes InstrE.
- RUN → DONE when PCF==HALT_PC. The matching cycle is still counted.
- DONE: counters frozen, Done=1. Start=1 clears the counters and returns to RUN.
- Start=1 during RUN restarts the window: counters cleared, the state stays RUN, and that cycle is not counted. When Start and the halt match occur in the same cycle, Start wins.
- RdSel map:
  - 0: Cycles
  - 1: StallCycles
  - 2: StallEvents
  - 3: Instrs
  - 4: Branches
  - 5: {WIDTH-2 zeros, Done, Running}
  - 6, 7: 0
- Counters wrap modulo 2^WIDTH by default; see Configuration.

## Timing
- Start sampled at edge N: Running=1 from edge N. The first counted cycle is the one following edge N.
- Halt match sampled at edge N: the counters include that cycle's increment, and Done=1 and Running=0 from edge N.
- RdData latency is 1 cycle. RdData at edge N+1 reflects RdSel and counter values as they stood after edge N, so it returns the pre-increment value of the cycle in which it is sampled.
- Asynchronous reset mid-window: all state clears immediately, with no residual counts.
- The wasStalled update and the StallEvents decision use the same-cycle stall. A stall spanning the Start edge counts as a new event in the first RUN cycle.

## Configuration
- PERFCNT_SATURATE_EN defined: each counter stops at all-ones, and further increments are ignored until the next Start or reset.
- PERFCNT_SATURATE_EN undefined: counters wrap to 0 after all-ones.

## Test plan
- Reset, then Start, then 10 cycles with no stall, a new InstrE every cycle, BranchE=0, then PCF=HALT_PC → Cycles=11, Instrs=11, StallCycles=0, Branches=0, Done=1, RdSel=5 reads 2.
- In RUN: StallD high for 3 cycles, low 2, StallE high 1, with InstrE constant during the stalls → StallCycles=4, StallEvents=2, and stalled cycles add no Instrs.
- InstrE held constant for 2 cycles with ForwardAE=2'b01 → Instrs +2. Changing InstrE with BranchE=1 → Branches +1.
- Start and halt match in the same cycle while in RUN → state stays RUN, all counters read 0 two cycles later, Done=0.
- Reset asserted asynchronously mid-window after 50 cycles → RdData, Running and Done go 0 before the next clk edge, and a new Start counts from 0.
- WIDTH=4, 20 RUN cycles → Cycles reads 4'hF with PERFCNT_SATURATE_EN, 4'h4 without.

Source files
------------

// File: rtl/perf_monitor.sv
// ---------------------------------------------------------------------------
// perf_monitor: windowed pipeline performance counters with registered readout.
// Rev 1.0. Optional PERFCNT_SATURATE_EN: counters saturate instead of wrapping.
// ---------------------------------------------------------------------------
`default_nettype none

module perf_monitor #(
   parameter int          WIDTH   = 32,
   parameter logic [31:0] HALT_PC = 32'hb6eac824
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             StallF,
   input  logic             StallD,
   input  logic             StallE,
   input  logic             StallM,
   input  logic             StallW,
   input  logic [1:0]       ForwardAE,
   input  logic [1:0]       ForwardBE,
   input  logic [31:0]      InstrE,
   input  logic             BranchE,
   input  logic [31:0]      PCF,
   input  logic             Start,
   input  logic [2:0]       RdSel,
   output logic [WIDTH-1:0] RdData,
   output logic             Running,
   output logic             Done
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             clear;
   logic             count;
   logic             stall;
   logic             chg;
   logic             fwd;
   logic             was_stalled;
   logic [31:0]      old_instr;
   logic [WIDTH-1:0] cycles;
   logic [WIDTH-1:0] stall_cycles;
   logic [WIDTH-1:0] stall_events;
   logic [WIDTH-1:0] instrs;
   logic [WIDTH-1:0] branches;
   logic [WIDTH-1:0] rd_mux;

   function automatic logic [WIDTH-1:0] bump(input logic [WIDTH-1:0] v, input logic en);
`ifdef PERFCNT_SATURATE_EN
      return (en && (v != '1)) ? v + ONE : v;
`else
      return en ? v + ONE : v;
`endif
   endfunction

   assign stall   = StallF | StallD | StallE | StallM | StallW;
   assign chg     = (InstrE != old_instr);
   assign fwd     = (ForwardAE != 2'b00) || (ForwardBE != 2'b00);
   assign Running = (state == RUN);
   assign Done    = (state == DONE);

   // Start has priority over the halt match, so a restart never lands in DONE.
   always_comb begin
      state_nxt = state;
      clear     = 1'b0;
      count     = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (Start) begin
               state_nxt = RUN;
               clear     = 1'b1;
            end
         end
         RUN: begin
            if (Start) begin
               clear = 1'b1;
            end else begin
               count = 1'b1;
               if (PCF == HALT_PC) state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycles       <= '0;
         stall_cycles <= '0;
         stall_events <= '0;
         instrs       <= '0;
         branches     <= '0;
         was_stalled  <= 1'b0;
         old_instr    <= 32'd0;
      end else if (clear) begin
         cycles       <= '0;
         stall_cycles <= '0;
         stall_events <= '0;
         instrs       <= '0;
         branches     <= '0;
         was_stalled  <= 1'b0;
         old_instr    <= InstrE;
      end else if (count) begin
         cycles       <= bump(cycles, 1'b1);
         stall_cycles <= bump(stall_cycles, stall);
         stall_events <= bump(stall_events, stall && !was_stalled);
         instrs       <= bump(instrs, chg || fwd);
         branches     <= bump(branches, chg && BranchE);
         was_stalled  <= stall;
         old_instr    <= InstrE;
      end
   end

   always_comb begin
      rd_mux = '0;
      case (RdSel)
         3'd0:    rd_mux = cycles;
         3'd1:    rd_mux = stall_cycles;
         3'd2:    rd_mux = stall_events;
         3'd3:    rd_mux = instrs;
         3'd4:    rd_mux = branches;
         3'd5:    rd_mux = {{(WIDTH-2){1'b0}}, Done, Running};
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) RdData <= '0;
      else       RdData <= rd_mux;
   end

endmodule

`default_nettype wire
